// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// IF_MISALIGN_TRAP_EN enables the HALT state and the fetch_misaligned flag.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h4000_0000;
    localparam logic [31:0] NOP_INSN     = 32'h0000_0013;

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        RUN      = 2'd1,
        HALT     = 2'd2
    } state_t;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: control inputs from ID/EX, addresses and tag to ID.
// IF_MISALIGN_TRAP_EN adds the fetch_misaligned signal.
interface if_stage_if #(
    parameter int BIOS_AW = 12,
    parameter int IMEM_AW = 14
);
    logic               stall;
    logic               ex_redirect;
    logic [31:0]        ex_redirect_pc;
    logic [31:0]        if_pc_target;
    logic               if_target_taken;
    logic [BIOS_AW-1:0] bios_addr;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        id_pc;
    logic               id_valid;
`ifdef IF_MISALIGN_TRAP_EN
    logic               fetch_misaligned;

    modport master (
        input  stall, ex_redirect, ex_redirect_pc,
        input  if_pc_target, if_target_taken,
        output bios_addr, imem_addr, id_pc, id_valid,
        output fetch_misaligned
    );
    modport slave (
        output stall, ex_redirect, ex_redirect_pc,
        output if_pc_target, if_target_taken,
        input  bios_addr, imem_addr, id_pc, id_valid,
        input  fetch_misaligned
    );
`else
    modport master (
        input  stall, ex_redirect, ex_redirect_pc,
        input  if_pc_target, if_target_taken,
        output bios_addr, imem_addr, id_pc, id_valid
    );
    modport slave (
        output stall, ex_redirect, ex_redirect_pc,
        output if_pc_target, if_target_taken,
        input  bios_addr, imem_addr, id_pc, id_valid
    );
`endif
endinterface

// File: rtl/if_stage_next_pc_sel.sv
// Combinational priority mux selecting the address issued this cycle.
module if_stage_next_pc_sel #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic        i_rst_wait,
    input  logic        i_halt,
    input  logic        i_ex_redirect,
    input  logic [31:0] i_ex_pc,
    input  logic        i_stall,
    input  logic        i_tgt_taken,
    input  logic [31:0] i_tgt_pc,
    input  logic [31:0] i_id_pc,
    output logic [31:0] o_fetch_pc
);
    always_comb begin
        o_fetch_pc = i_id_pc + 32'd4;
        if (i_rst_wait)
            o_fetch_pc = RESET_PC;
        else if (i_halt)
            o_fetch_pc = i_id_pc;
        else if (i_ex_redirect)
            o_fetch_pc = i_ex_pc;
        // re-read the held word so the sync-read output stays stable
        else if (i_stall)
            o_fetch_pc = i_id_pc;
        else if (i_tgt_taken)
            o_fetch_pc = i_tgt_pc;
    end
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns fetch PC, tags memory data with id_pc.
// IF_MISALIGN_TRAP_EN adds a sticky misaligned-target trap and HALT.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          BIOS_AW  = 12,
    parameter int          IMEM_AW  = 14
) (
    input  logic       clk,
    input  logic       rst,
    if_stage_if.master bus
);
    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_id_pc;
    logic [31:0] w_fetch_pc;
    logic        w_load;
    logic        w_trap;

    if_stage_next_pc_sel #(.RESET_PC(RESET_PC)) u_sel (
        .i_rst_wait    (r_state == RST_WAIT),
        .i_halt        (r_state == HALT),
        .i_ex_redirect (bus.ex_redirect),
        .i_ex_pc       (bus.ex_redirect_pc),
        .i_stall       (bus.stall),
        .i_tgt_taken   (bus.if_target_taken),
        .i_tgt_pc      (bus.if_pc_target),
        .i_id_pc       (r_id_pc),
        .o_fetch_pc    (w_fetch_pc)
    );

`ifdef IF_MISALIGN_TRAP_EN
    logic r_misaligned;

    assign w_trap = (r_state == RUN) &&
        ((bus.ex_redirect && (|bus.ex_redirect_pc[1:0])) ||
         (!bus.ex_redirect && !bus.stall &&
          bus.if_target_taken && (|bus.if_pc_target[1:0])));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_misaligned <= 1'b0;
        else if (w_trap)
            r_misaligned <= 1'b1;
    end

    assign bus.fetch_misaligned = r_misaligned;
`else
    assign w_trap = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        unique case (r_state)
            RST_WAIT: begin
                w_next = RUN;
                w_load = 1'b1;
            end
            RUN: begin
                // faulting target is never committed to id_pc
                if (w_trap)
                    w_next = HALT;
                else
                    w_load = 1'b1;
            end
            HALT:    w_next = HALT;
            default: w_next = RST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RST_WAIT;
            r_id_pc <= RESET_PC;
        end else begin
            r_state <= w_next;
            if (w_load)
                r_id_pc <= w_fetch_pc;
        end
    end

    assign bus.bios_addr = w_fetch_pc[BIOS_AW+1:2];
    assign bus.imem_addr = w_fetch_pc[IMEM_AW+1:2];
    assign bus.id_pc     = r_id_pc;
    assign bus.id_valid  = (r_state == RUN);
endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage.
// Build with +define+IF_MISALIGN_TRAP_EN to exercise the trap path.
module tb_if_stage;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    if_stage_if #(.BIOS_AW(12), .IMEM_AW(14)) bus ();

    if_stage #(
        .RESET_PC (32'h4000_0000),
        .BIOS_AW  (12),
        .IMEM_AW  (14)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic goto_pc(input logic [31:0] pc);
        @(negedge clk);
        bus.ex_redirect    = 1'b1;
        bus.ex_redirect_pc = pc;
        @(negedge clk);
        bus.ex_redirect    = 1'b0;
        n_tests++;
        if (bus.id_pc !== pc) begin
            n_fail++;
            $display("FAIL goto id_pc got %h need %h", bus.id_pc, pc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_valid got %b need 0", bus.id_valid);
        end
        n_tests++;
        if (bus.bios_addr !== 12'h000) begin
            n_fail++;
            $display("FAIL rst_bios got %h need 000", bus.bios_addr);
        end
        n_tests++;
        if (bus.id_pc !== 32'h4000_0000) begin
            n_fail++;
            $display("FAIL rst_pc got %h need 40000000", bus.id_pc);
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.id_pc !== 32'h4000_0000 || bus.id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rel_first got %h/%b need 40000000/1",
                     bus.id_pc, bus.id_valid);
        end
        @(negedge clk);
        n_tests++;
        if (bus.id_pc !== 32'h4000_0004) begin
            n_fail++;
            $display("FAIL rel_seq1 got %h need 40000004", bus.id_pc);
        end
        @(negedge clk);
        n_tests++;
        if (bus.id_pc !== 32'h4000_0008 || bus.bios_addr !== 12'h003) begin
            n_fail++;
            $display("FAIL rel_seq2 got %h/%h need 40000008/003",
                     bus.id_pc, bus.bios_addr);
        end
    endtask

    task automatic test_target();
        goto_pc(32'h1000_0010);
        bus.if_target_taken = 1'b1;
        bus.if_pc_target    = 32'h1000_0100;
        #1;
        n_tests++;
        if (bus.imem_addr !== 14'h0040) begin
            n_fail++;
            $display("FAIL tgt_addr got %h need 0040", bus.imem_addr);
        end
        @(negedge clk);
        bus.if_target_taken = 1'b0;
        n_tests++;
        if (bus.id_pc !== 32'h1000_0100 || bus.id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL tgt_pc got %h/%b need 10000100/1",
                     bus.id_pc, bus.id_valid);
        end
        @(negedge clk);
        n_tests++;
        if (bus.id_pc !== 32'h1000_0104) begin
            n_fail++;
            $display("FAIL tgt_next got %h need 10000104", bus.id_pc);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] tgts [3];
        tgts[0] = 32'h2000_0000;
        tgts[1] = 32'h2000_0040;
        tgts[2] = 32'h2000_0008;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.if_target_taken = 1'b1;
            bus.if_pc_target    = tgts[i];
            #1;
            n_tests++;
            if (bus.imem_addr !== tgts[i][15:2]) begin
                n_fail++;
                $display("FAIL b2b_addr%0d got %h need %h",
                         i, bus.imem_addr, tgts[i][15:2]);
            end
        end
        @(negedge clk);
        bus.if_target_taken = 1'b0;
        n_tests++;
        if (bus.id_pc !== 32'h2000_0008) begin
            n_fail++;
            $display("FAIL b2b_pc got %h need 20000008", bus.id_pc);
        end
    endtask

    task automatic test_stall();
        goto_pc(32'h1000_0020);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (bus.imem_addr !== 14'h0008) begin
                n_fail++;
                $display("FAIL stall_addr%0d got %h need 0008",
                         i, bus.imem_addr);
            end
            @(negedge clk);
            n_tests++;
            if (bus.id_pc !== 32'h1000_0020) begin
                n_fail++;
                $display("FAIL stall_pc%0d got %h need 10000020",
                         i, bus.id_pc);
            end
        end
        bus.stall = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.id_pc !== 32'h1000_0024) begin
            n_fail++;
            $display("FAIL stall_rel got %h need 10000024", bus.id_pc);
        end
    endtask

    task automatic test_priority();
        goto_pc(32'h1000_0040);
        bus.stall           = 1'b1;
        bus.if_target_taken = 1'b1;
        bus.if_pc_target    = 32'h1000_0200;
        bus.ex_redirect     = 1'b1;
        bus.ex_redirect_pc  = 32'h1000_0300;
        #1;
        n_tests++;
        if (bus.imem_addr !== 14'h00C0) begin
            n_fail++;
            $display("FAIL prio_addr got %h need 00c0", bus.imem_addr);
        end
        @(negedge clk);
        bus.ex_redirect = 1'b0;
        n_tests++;
        if (bus.id_pc !== 32'h1000_0300) begin
            n_fail++;
            $display("FAIL prio_ex got %h need 10000300", bus.id_pc);
        end
        @(negedge clk);
        n_tests++;
        if (bus.id_pc !== 32'h1000_0300) begin
            n_fail++;
            $display("FAIL prio_hold got %h need 10000300", bus.id_pc);
        end
        bus.stall           = 1'b0;
        bus.if_target_taken = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.id_pc !== 32'h1000_0304) begin
            n_fail++;
            $display("FAIL prio_rel got %h need 10000304", bus.id_pc);
        end
    endtask

    task automatic test_wrap();
        goto_pc(32'hFFFF_FFFC);
        #1;
        n_tests++;
        if (bus.imem_addr !== 14'h0000) begin
            n_fail++;
            $display("FAIL wrap_addr got %h need 0000", bus.imem_addr);
        end
        @(negedge clk);
        n_tests++;
        if (bus.id_pc !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL wrap_pc got %h need 00000000", bus.id_pc);
        end
    endtask

`ifndef IF_MISALIGN_TRAP_EN
    task automatic test_align();
        @(negedge clk);
        bus.ex_redirect    = 1'b1;
        bus.ex_redirect_pc = 32'h1000_0103;
        #1;
        n_tests++;
        if (bus.imem_addr !== 14'h0040 || bus.bios_addr !== 12'h040) begin
            n_fail++;
            $display("FAIL align_addr got %h/%h need 0040/040",
                     bus.imem_addr, bus.bios_addr);
        end
        @(negedge clk);
        bus.ex_redirect = 1'b0;
        n_tests++;
        if (bus.id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL align_valid got %b need 1", bus.id_valid);
        end
    endtask
`endif

    task automatic test_midreset();
        goto_pc(32'h1000_0080);
        bus.ex_redirect    = 1'b1;
        bus.ex_redirect_pc = 32'h1000_0400;
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.id_valid !== 1'b0 || bus.id_pc !== 32'h4000_0000) begin
            n_fail++;
            $display("FAIL mid_rst got %h/%b need 40000000/0",
                     bus.id_pc, bus.id_valid);
        end
        @(negedge clk);
        bus.ex_redirect = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.id_pc !== 32'h4000_0000 || bus.id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_rel got %h/%b need 40000000/1",
                     bus.id_pc, bus.id_valid);
        end
    endtask

`ifdef IF_MISALIGN_TRAP_EN
    task automatic test_trap();
        goto_pc(32'h1000_0040);
        n_tests++;
        if (bus.fetch_misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL trap_pre got %b need 0", bus.fetch_misaligned);
        end
        bus.ex_redirect    = 1'b1;
        bus.ex_redirect_pc = 32'h1000_0002;
        @(negedge clk);
        bus.ex_redirect = 1'b0;
        n_tests++;
        if (bus.fetch_misaligned !== 1'b1 || bus.id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL trap_set got %b/%b need 1/0",
                     bus.fetch_misaligned, bus.id_valid);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.id_pc !== 32'h1000_0040 || bus.imem_addr !== 14'h0010) begin
            n_fail++;
            $display("FAIL trap_frz got %h/%h need 10000040/0010",
                     bus.id_pc, bus.imem_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.fetch_misaligned !== 1'b0 || bus.id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL trap_clr got %b/%b need 0/1",
                     bus.fetch_misaligned, bus.id_valid);
        end
    endtask
`endif

    initial begin
        n_tests             = 0;
        n_fail              = 0;
        rst                 = 1'b0;
        bus.stall           = 1'b0;
        bus.ex_redirect     = 1'b0;
        bus.ex_redirect_pc  = 32'h0;
        bus.if_pc_target    = 32'h0;
        bus.if_target_taken = 1'b0;
        test_reset();
        test_target();
        test_back_to_back();
        test_stall();
        test_priority();
        test_wrap();
`ifndef IF_MISALIGN_TRAP_EN
        test_align();
`endif
        test_midreset();
`ifdef IF_MISALIGN_TRAP_EN
        test_trap();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
